// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the default operand width.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/adder_n.sv
// Plain WIDTH-bit adder with carry-out, used for the partial-product add.
module adder_n #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mult_unit.sv
// MIPS-style MULT/MULTU: magnitudes are multiplied by WIDTH shift-add steps,
// then the sign is applied in one extra cycle before hi/lo are updated.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output mult_state_e       dbg_state
);

    mult_state_e        state_q;
    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_abs_d;
    logic [WIDTH-1:0]   b_abs_d;
    logic               neg_d;
    logic [WIDTH-1:0]   add_b_w;
    logic [WIDTH-1:0]   add_sum_w;
    logic               add_co_w;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] result_d;

    // Signed operands are reduced to magnitudes; 0x80..0 maps to 2^(WIDTH-1).
    assign a_abs_d = (is_signed && a[WIDTH-1]) ? ('0 - a) : a;
    assign b_abs_d = (is_signed && b[WIDTH-1]) ? ('0 - b) : b;
    assign neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    assign add_b_w = acc_q[0] ? mcand_q : '0;

    adder_n #(.WIDTH(WIDTH)) u_pp_add (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (add_b_w),
        .sum_o  (add_sum_w),
        .cout_o (add_co_w)
    );

    // The carry re-enters at the top as {carry,acc} shifts right by one.
    assign acc_d    = {add_co_w, add_sum_w, acc_q[WIDTH-1:1]};
    assign result_d = neg_q ? ('0 - acc_q) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q <= a_abs_d;
                        acc_q   <= {{WIDTH{1'b0}}, b_abs_d};
                        neg_q   <= neg_d;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == WIDTH'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SIGN;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                SIGN: begin
                    hi_q    <= result_d[2*WIDTH-1:WIDTH];
                    lo_q    <= result_d[WIDTH-1:0];
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN) || (state_q == SIGN);
    assign done      = (state_q == DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the product is 2*WIDTH bits.
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port start, input, 1, request to begin a multiply; sampled only when busy=0.
REQ-005 Port is_signed, input, 1, 1 selects MULT (two's complement), 0 selects MULTU; sampled with start.
REQ-006 Port a, input, WIDTH, multiplicand; sampled with start.
REQ-007 Port b, input, WIDTH, multiplier; sampled with start.
REQ-008 Port clear, input, 1, synchronous abort; returns the block to IDLE.
REQ-009 Port busy, output, 1, high while an operation is in progress (RUN or SIGN).
REQ-010 Port done, output, 1, single-cycle pulse when hi/lo hold a new result.
REQ-011 Port hi, output, WIDTH, upper half of the product.
REQ-012 Port lo, output, WIDTH, lower half of the product.

Function
REQ-013 The block SHALL use four states: IDLE, RUN, SIGN, DONE.
REQ-014 IDLE/DONE with start=1 and clear=0 SHALL latch a, b and is_signed and go to RUN; otherwise DONE->IDLE and IDLE holds.
REQ-015 On start with is_signed=1, the block SHALL latch |a| and |b| and record neg = a[WIDTH-1] XOR b[WIDTH-1]; with is_signed=0, neg=0 and operands latch unchanged.
REQ-016 RUN SHALL take exactly WIDTH cycles, one shift-add iteration per cycle: if accumulator bit 0 is 1, add the multiplicand to the upper WIDTH bits with carry out, then shift the (2*WIDTH+1)-bit {carry,acc} right by one.
REQ-017 A WIDTH-bit iteration counter SHALL count 0..WIDTH-1; RUN->SIGN when the count reaches WIDTH-1.
REQ-018 SIGN SHALL last one cycle: the 2*WIDTH-bit result is two's-complement negated if neg=1, then written to hi/lo, and the state goes to DONE.
REQ-019 done SHALL be 1 only in DONE; latency from the start-sampling edge to done=1 is WIDTH+2 rising edges.
REQ-020 busy SHALL be 1 in RUN and SIGN, 0 in IDLE and DONE.
REQ-021 start while busy=1 SHALL be ignored, and the operands, state and counter SHALL not change.
REQ-022 start asserted during DONE SHALL be accepted; done still pulses that cycle and the next operation proceeds without an idle gap.
REQ-023 hi/lo SHALL change only at the SIGN->DONE edge and otherwise hold their last result, including across clear.
REQ-024 clear=1 SHALL force IDLE on the next edge from any state and discard the operation in progress, and SHALL take priority over start in the same cycle.
REQ-025 The MIPS result SHALL be exact: the signed product is the 2*WIDTH-bit two's-complement value and the unsigned product has full width with no overflow.

Reset
REQ-026 rst_n=0 SHALL immediately set state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0 and clear the internal operand/accumulator registers, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; after release the block SHALL accept start on the first rising edge.

Structure
REQ-028 A shared package mult_pkg SHALL hold the state encoding (IDLE, RUN, SIGN, DONE) and the default WIDTH constant.
REQ-029 One sub-module adder_n (WIDTH-bit sum with carry-out) SHALL be instantiated for the partial-product add; the SIGN negation MAY reuse a second instance.
REQ-030 All other logic (FSM, counter, registers) SHALL reside in mult_unit.

Verification
REQ-031 Unsigned: a=3, b=5, start -> done after 34 edges, hi=0x00000000, lo=0x0000000F.
REQ-032 Unsigned max: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Signed: a=0xFFFFFFFF (-1), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9; a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 start pulsed at cycle 10 of RUN with different operands -> ignored; the first result is unchanged and done pulses exactly once.
REQ-035 rst_n pulled low mid-RUN -> busy=0, hi=lo=0 at once; a new start after release gives the correct result after 34 edges.
REQ-036 clear at cycle 5 of RUN -> IDLE next edge, no done, hi/lo keep the previous result; start held during DONE -> back-to-back results with done pulses 34 edges apart.
